data_memory: RTL and testbench

Byte-addressable, little-endian data memory for the load/store stage of the pipelined RISC-V core. Supports word, halfword and byte stores with per-byte write enables, and returns the addressed element right-aligned and zero-extended on a combinational read port. Sign extension for loads is done downstream, not here.

---
 rtl/data_memory_pkg.sv | 14 +
 rtl/data_mem_lane_ctrl.sv | 38 +++
 rtl/data_memory.sv | 68 ++++++
 tb/tb_data_memory.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared access-width encodings for the load/store path.
// Also used by the decode stage and the load-extension logic.
package data_memory_pkg;

  typedef enum logic [1:0] {
    WIDTH_WORD = 2'b00,
    WIDTH_BYTE = 2'b01,
    WIDTH_HALF = 2'b10,
    WIDTH_RSVD = 2'b11
  } width_e;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/data_mem_lane_ctrl.sv
// Byte-lane write control for the data memory.
// Turns an access width and byte offset into a 4-bit lane enable mask.
// Replicates the store element across lanes so every enabled lane sees its own bits.
module data_mem_lane_ctrl
  import data_memory_pkg::*;
(
  input  logic [1:0]  width_src,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] wd,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_data
);

  // Decode width and offset into lane enables and replicated write data
  always_comb begin
    byte_en = 4'b0000;
    wr_data = wd;
    case (width_src)
      WIDTH_WORD: begin
        byte_en = 4'b1111;
        wr_data = wd;
      end
      WIDTH_HALF: begin
        byte_en = byte_sel[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wd[15:0]}};
      end
      WIDTH_BYTE: begin
        byte_en = 4'b0001 << byte_sel;
        wr_data = {4{wd[7:0]}};
      end
      default: begin
        byte_en = 4'b0000;
        wr_data = wd;
      end
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory for the load/store stage.
// Stores word/half/byte elements through per-lane enables; reads are combinational,
// right-aligned and zero-extended (sign extension happens downstream).
// Out-of-range addresses wrap because upper address bits are ignored.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        WE,
  input  logic [1:0]  width_src,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [7:0]    mem [DEPTH_WORDS][BYTES_PER_WORD];
  logic [AW-1:0] word_idx;
  logic [3:0]    byte_en;
  logic [31:0]   wr_data;
  logic [31:0]   rd_word;
  logic          unused_addr_bits;

  assign word_idx         = A[AW+1:2];
  assign unused_addr_bits = ^A[31:AW+2];

  data_mem_lane_ctrl u_lane_ctrl (
    .width_src (width_src),
    .byte_sel  (A[1:0]),
    .wd        (WD),
    .byte_en   (byte_en),
    .wr_data   (wr_data)
  );

  // Storage: asynchronous clear of every byte, otherwise per-lane writes on the clock edge
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int w = 0; w < DEPTH_WORDS; w++) begin
        for (int l = 0; l < BYTES_PER_WORD; l++) begin
          mem[w][l] <= 8'h00;
        end
      end
    end else if (WE) begin
      for (int l = 0; l < BYTES_PER_WORD; l++) begin
        if (byte_en[l]) begin
          mem[word_idx][l] <= wr_data[8*l +: 8];
        end
      end
    end
  end

  assign rd_word = {mem[word_idx][3], mem[word_idx][2], mem[word_idx][1], mem[word_idx][0]};

  // Read mux: select the addressed element and zero-extend it; reserved width reads the full word
  always_comb begin
    RD = rd_word;
    case (width_src)
      WIDTH_HALF: RD = A[1] ? {16'h0000, rd_word[31:16]} : {16'h0000, rd_word[15:0]};
      WIDTH_BYTE: RD = {24'h000000, mem[word_idx][A[1:0]]};
      default:    RD = rd_word;
    endcase
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory.
// Keeps a flat byte-array reference model and checks directed and random traffic against it.
module tb_data_memory;

  localparam int DEPTH = 64;
  localparam int CAP   = 4 * DEPTH;

  logic        clk_i;
  logic        reset_i;
  logic        WE;
  logic [1:0]  width_src;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] RD;

  logic [7:0]  ref_mem [CAP];
  int          compare_count;
  int          fail_count;
  logic [31:0] rd_val;

  data_memory #(.DEPTH_WORDS(DEPTH)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .WE        (WE),
    .width_src (width_src),
    .A         (A),
    .WD        (WD),
    .RD        (RD)
  );

  // 10 ns clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic void model_clear();
    for (int i = 0; i < CAP; i++) ref_mem[i] = 8'h00;
  endfunction

  // Reference read: byte address modulo capacity, little-endian, zero-extended
  function automatic logic [31:0] model_read(input logic [1:0] w, input logic [31:0] a);
    int base;
    base = int'(a % CAP);
    case (w)
      2'b10: begin
        base = base - (base % 2);
        return {16'h0000, ref_mem[base+1], ref_mem[base]};
      end
      2'b01: return {24'h000000, ref_mem[base]};
      default: begin
        base = base - (base % 4);
        return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
      end
    endcase
  endfunction

  function automatic void model_write(input logic we, input logic [1:0] w,
                                      input logic [31:0] a, input logic [31:0] d);
    int base;
    if (!we) return;
    base = int'(a % CAP);
    case (w)
      2'b00: begin
        base = base - (base % 4);
        for (int k = 0; k < 4; k++) ref_mem[base+k] = d[8*k +: 8];
      end
      2'b10: begin
        base = base - (base % 2);
        for (int k = 0; k < 2; k++) ref_mem[base+k] = d[8*k +: 8];
      end
      2'b01: ref_mem[base] = d[7:0];
      default: ;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h (A=%h width=%b)", tag, observed, expected, A, width_src);
    end
  endtask

  // One clocked access: pre-edge read shows old data, post-edge read shows the new data
  task automatic applyStimulus(input logic we, input logic [1:0] w,
                               input logic [31:0] a, input logic [31:0] d);
    @(negedge clk_i);
    WE = we; width_src = w; A = a; WD = d;
    #1;
    checkOutput("pre_edge", RD, model_read(w, a));
    @(posedge clk_i);
    model_write(we, w, a, d);
    #1;
    checkOutput("post_edge", RD, model_read(w, a));
  endtask

  task automatic readAt(input logic [1:0] w, input logic [31:0] a, output logic [31:0] val);
    @(negedge clk_i);
    WE = 1'b0; width_src = w; A = a;
    #1;
    val = RD;
  endtask

  initial begin
    compare_count = 0;
    fail_count    = 0;
    model_clear();
    reset_i = 1'b1; WE = 1'b0; width_src = 2'b00; A = 32'h0; WD = 32'h0;

    // Reset state
    #2;
    checkOutput("reset_a0", RD, 32'h0);
    A = 32'h0000_00FC; #1;
    checkOutput("reset_afc", RD, 32'h0);
    @(negedge clk_i);
    reset_i = 1'b0;

    // Word fill
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 2'b00, 32'(4*i), 32'(i));
      checkOutput("word_fill", RD, 32'(i));
    end
    for (int i = 0; i < DEPTH; i += 9) begin
      for (int k = 1; k < 4; k++) begin
        readAt(2'b00, 32'(4*i+k), rd_val);
        checkOutput("word_unaligned", rd_val, 32'(i));
      end
    end

    // Halfword fill
    for (int i = 0; i < 2*DEPTH; i++) applyStimulus(1'b1, 2'b10, 32'(2*i), 32'(i));
    for (int i = 0; i < 2*DEPTH; i++) begin
      readAt(2'b10, 32'(2*i), rd_val);
      checkOutput("half_read", rd_val, 32'(i));
    end
    readAt(2'b10, 32'd6, rd_val);
    checkOutput("half_a6", rd_val, 32'h0000_0003);

    // Byte fill
    for (int i = 0; i < CAP; i++) applyStimulus(1'b1, 2'b01, 32'(i), 32'(i));
    for (int i = 0; i < CAP; i++) begin
      readAt(2'b01, 32'(i), rd_val);
      checkOutput("byte_read", rd_val, 32'(i));
    end
    readAt(2'b00, 32'd4, rd_val);
    checkOutput("byte_word_a4", rd_val, 32'h0706_0504);

    // Partial writes preserve neighbours
    applyStimulus(1'b1, 2'b00, 32'd0, 32'hAABB_CCDD);
    applyStimulus(1'b1, 2'b01, 32'd2, 32'h0000_0011);
    readAt(2'b00, 32'd0, rd_val);
    checkOutput("partial_byte", rd_val, 32'hAA11_CCDD);
    applyStimulus(1'b1, 2'b10, 32'd0, 32'h0000_2233);
    readAt(2'b00, 32'd0, rd_val);
    checkOutput("partial_half", rd_val, 32'hAA11_2233);

    // Reserved width writes nothing and reads the full word
    applyStimulus(1'b1, 2'b11, 32'd0, 32'hFFFF_FFFF);
    checkOutput("reserved_read", RD, 32'hAA11_2233);

    // WE=0 leaves storage unchanged
    applyStimulus(1'b0, 2'b00, 32'd0, 32'h1234_5678);
    checkOutput("we_low", RD, 32'hAA11_2233);

    // Address wrap
    applyStimulus(1'b1, 2'b00, 32'd256, 32'hCAFE_F00D);
    readAt(2'b00, 32'd0, rd_val);
    checkOutput("wrap_alias", rd_val, 32'hCAFE_F00D);

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
    end

    // Asynchronous reset between edges clears immediately
    applyStimulus(1'b1, 2'b00, 32'd12, 32'h5A5A_A5A5);
    @(negedge clk_i);
    WE = 1'b0; width_src = 2'b00; A = 32'd12;
    #2;
    reset_i = 1'b1;
    model_clear();
    #1;
    checkOutput("async_reset_a12", RD, 32'h0);
    A = 32'd0; #1;
    checkOutput("async_reset_a0", RD, 32'h0);

    // Write edge coinciding with reset is discarded
    WE = 1'b1; width_src = 2'b00; A = 32'd8; WD = 32'hDEAD_BEEF;
    @(posedge clk_i);
    #1;
    checkOutput("reset_write_edge", RD, 32'h0);
    @(negedge clk_i);
    reset_i = 1'b0; WE = 1'b0;
    readAt(2'b00, 32'd8, rd_val);
    checkOutput("reset_write_after", rd_val, 32'h0);

    // Post-reset operation still works
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
